// File: rtl/octave_sel.sv
// octave_sel: turns octave up/down button levels into a saturating or wrapping
// octave index with optional hold-to-auto-repeat, plus change/limit pulses.
`default_nettype none

module octave_sel #(
    parameter  int NUM_OCT    = 4,
    parameter  int RESET_OCT  = 0,
    parameter  int WRAP       = 1,
    parameter  int REPEAT_DLY = 0,
    parameter  int REPEAT_PER = 1,
    localparam int W          = $clog2(NUM_OCT)
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         oct_up,
    input  logic         oct_down,
    output logic [W-1:0] oct_sel,
    output logic         oct_changed,
    output logic         limit_hit,
    output logic         at_min,
    output logic         at_max
);

    localparam logic [1:0]   S_IDLE   = 2'd0;
    localparam logic [1:0]   S_HOLD   = 2'd1;
    localparam logic [1:0]   S_REPEAT = 2'd2;

    localparam logic [W-1:0] C_MAX    = W'(NUM_OCT - 1);
    localparam logic [W-1:0] C_RST    = W'(RESET_OCT);
    localparam logic [15:0]  C_DLY_M1 = (REPEAT_DLY > 0) ? 16'(REPEAT_DLY - 1) : 16'd0;
    localparam logic [15:0]  C_PER_M1 = (REPEAT_PER > 0) ? 16'(REPEAT_PER - 1) : 16'd0;

    logic [1:0]   state_q, state_d;
    logic         dir_q, dir_d;       // 1 = down button held, 0 = up button held
    logic [15:0]  cnt_q, cnt_d;
    logic [W-1:0] sel_q, sel_d;
    logic         chg_q, chg_d;
    logic         lim_q, lim_d;
    logic         up_prev_q, dn_prev_q;

    logic         w_up_only;
    logic         w_dn_only;
    logic         w_held;
    logic         w_opp;
    logic         w_step_en;
    logic         w_step_dn;

    // A press requires the other button to be low; simultaneous activity is no press.
    assign w_up_only = oct_up   & ~up_prev_q & ~oct_down;
    assign w_dn_only = oct_down & ~dn_prev_q & ~oct_up;
    assign w_held    = dir_q ? oct_down : oct_up;
    assign w_opp     = dir_q ? oct_up   : oct_down;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        w_step_en = 1'b0;
        w_step_dn = dir_q;
        case (state_q)
            S_IDLE: begin
                if (w_up_only || w_dn_only) begin
                    w_step_en = 1'b1;
                    w_step_dn = w_dn_only;
                    dir_d     = w_dn_only;
                    cnt_d     = 16'd0;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_held || w_opp) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else if (REPEAT_DLY != 0) begin
                    if (cnt_q == C_DLY_M1) begin
                        w_step_en = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = S_REPEAT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_REPEAT: begin
                if (!w_held || w_opp) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == C_PER_M1) begin
                    w_step_en = 1'b1;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        chg_d = 1'b0;
        lim_d = 1'b0;
        if (w_step_en) begin
            if (w_step_dn) begin
                if (sel_q != C_MAX) begin
                    sel_d = sel_q + W'(1);
                    chg_d = 1'b1;
                end else if (WRAP != 0) begin
                    sel_d = '0;
                    chg_d = 1'b1;
                end else begin
                    lim_d = 1'b1;
                end
            end else begin
                if (sel_q != '0) begin
                    sel_d = sel_q - W'(1);
                    chg_d = 1'b1;
                end else if (WRAP != 0) begin
                    sel_d = C_MAX;
                    chg_d = 1'b1;
                end else begin
                    lim_d = 1'b1;
                end
            end
        end
    end

    // Previous-sample registers reset high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            cnt_q     <= 16'd0;
            sel_q     <= C_RST;
            chg_q     <= 1'b0;
            lim_q     <= 1'b0;
            up_prev_q <= 1'b1;
            dn_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            chg_q     <= chg_d;
            lim_q     <= lim_d;
            up_prev_q <= oct_up;
            dn_prev_q <= oct_down;
        end
    end

    assign oct_sel     = sel_q;
    assign oct_changed = chg_q;
    assign limit_hit   = lim_q;
    assign at_min      = (sel_q == '0);
    assign at_max      = (sel_q == C_MAX);

endmodule

`default_nettype wire

// File: tb/tb_octave_sel.sv
// tb_octave_sel: directed checks of octave_sel across several parameter sets.
`default_nettype none

module tb_octave_sel;

    logic       clk = 1'b0;
    logic       nrst;
    logic [5:0] up_v;
    logic [5:0] dn_v;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    // Instance indices: 0 default, 1 saturating, 2 auto-repeat, 3/4/5 sweep N=2/5/16.
    logic [1:0] def_sel; logic def_chg, def_lim, def_min, def_max;
    logic [1:0] sat_sel; logic sat_chg, sat_lim, sat_min, sat_max;
    logic [2:0] rep_sel; logic rep_chg, rep_lim, rep_min, rep_max;
    logic [0:0] n2_sel;  logic n2_chg,  n2_lim,  n2_min,  n2_max;
    logic [2:0] n5_sel;  logic n5_chg,  n5_lim,  n5_min,  n5_max;
    logic [3:0] n16_sel; logic n16_chg, n16_lim, n16_min, n16_max;

    octave_sel u_def (
        .clk(clk), .nrst(nrst), .oct_up(up_v[0]), .oct_down(dn_v[0]),
        .oct_sel(def_sel), .oct_changed(def_chg), .limit_hit(def_lim),
        .at_min(def_min), .at_max(def_max));

    octave_sel #(.NUM_OCT(3), .WRAP(0)) u_sat (
        .clk(clk), .nrst(nrst), .oct_up(up_v[1]), .oct_down(dn_v[1]),
        .oct_sel(sat_sel), .oct_changed(sat_chg), .limit_hit(sat_lim),
        .at_min(sat_min), .at_max(sat_max));

    octave_sel #(.NUM_OCT(8), .REPEAT_DLY(10), .REPEAT_PER(4)) u_rep (
        .clk(clk), .nrst(nrst), .oct_up(up_v[2]), .oct_down(dn_v[2]),
        .oct_sel(rep_sel), .oct_changed(rep_chg), .limit_hit(rep_lim),
        .at_min(rep_min), .at_max(rep_max));

    octave_sel #(.NUM_OCT(2), .RESET_OCT(1)) u_n2 (
        .clk(clk), .nrst(nrst), .oct_up(up_v[3]), .oct_down(dn_v[3]),
        .oct_sel(n2_sel), .oct_changed(n2_chg), .limit_hit(n2_lim),
        .at_min(n2_min), .at_max(n2_max));

    octave_sel #(.NUM_OCT(5), .RESET_OCT(4)) u_n5 (
        .clk(clk), .nrst(nrst), .oct_up(up_v[4]), .oct_down(dn_v[4]),
        .oct_sel(n5_sel), .oct_changed(n5_chg), .limit_hit(n5_lim),
        .at_min(n5_min), .at_max(n5_max));

    octave_sel #(.NUM_OCT(16), .RESET_OCT(15)) u_n16 (
        .clk(clk), .nrst(nrst), .oct_up(up_v[5]), .oct_down(dn_v[5]),
        .oct_sel(n16_sel), .oct_changed(n16_chg), .limit_hit(n16_lim),
        .at_min(n16_min), .at_max(n16_max));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_of(input int idx);
        case (idx)
            0:       return 32'(def_sel);
            1:       return 32'(sat_sel);
            2:       return 32'(rep_sel);
            3:       return 32'(n2_sel);
            4:       return 32'(n5_sel);
            default: return 32'(n16_sel);
        endcase
    endfunction

    // Flags packed as {limit_hit, oct_changed, at_max, at_min}.
    function automatic logic [3:0] flags_of(input int idx);
        case (idx)
            0:       return {def_lim, def_chg, def_max, def_min};
            1:       return {sat_lim, sat_chg, sat_max, sat_min};
            2:       return {rep_lim, rep_chg, rep_max, rep_min};
            3:       return {n2_lim,  n2_chg,  n2_max,  n2_min};
            4:       return {n5_lim,  n5_chg,  n5_max,  n5_min};
            default: return {n16_lim, n16_chg, n16_max, n16_min};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx, input bit down);
        if (down) dn_v[idx] = 1'b1;
        else      up_v[idx] = 1'b1;
        tick();
    endtask

    task automatic rel(input int idx);
        up_v[idx] = 1'b0;
        dn_v[idx] = 1'b0;
        tick();
    endtask

    task automatic chk_state(input string tag, input int idx, input int sel,
                             input logic [3:0] flags);
        check({tag, " sel"},   sel_of(idx), 32'(sel));
        check({tag, " flags"}, 32'(flags_of(idx)), 32'(flags));
    endtask

    initial begin
        int exp_sel;
        int n;
        logic [3:0] f;
        nrst = 1'b0;
        up_v = '0;
        dn_v = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_state("rst_def", 0, 0, 4'b0001);
        chk_state("rst_n16", 5, 15, 4'b0010);
        nrst = 1'b1;
        tick();
        chk_state("post_rst_def", 0, 0, 4'b0001);
        chk_state("post_rst_sat", 1, 0, 4'b0001);

        // Wrapping down presses on the default instance.
        begin
            int exp_seq[5] = '{1, 2, 3, 0, 1};
            for (int i = 0; i < 5; i++) begin
                press(0, 1'b1);
                f = {1'b0, 1'b1, exp_seq[i] == 3, exp_seq[i] == 0};
                chk_state($sformatf("def_dn%0d", i), 0, exp_seq[i], f);
                rel(0);
                check($sformatf("def_dn%0d_chg_clr", i), 32'(def_chg), 0);
            end
        end

        // Saturation, NUM_OCT=3, WRAP=0.
        press(1, 1'b1); chk_state("sat_dn0", 1, 1, 4'b0100); rel(1);
        press(1, 1'b1); chk_state("sat_dn1", 1, 2, 4'b0110); rel(1);
        press(1, 1'b1); chk_state("sat_dn2", 1, 2, 4'b1010); rel(1);
        check("sat_lim_clr", 32'(sat_lim), 0);
        press(1, 1'b0); chk_state("sat_up", 1, 1, 4'b0100); rel(1);

        // Sweep with RESET_OCT = N-1: wrap at both ends in both directions.
        for (int idx = 3; idx <= 5; idx++) begin
            n = (idx == 3) ? 2 : (idx == 4) ? 5 : 16;
            chk_state($sformatf("sw%0d_rst", n), idx, n - 1, 4'b0010);
            press(idx, 1'b1);
            chk_state($sformatf("sw%0d_wrap_dn", n), idx, 0, 4'b0101);
            rel(idx);
            press(idx, 1'b0);
            chk_state($sformatf("sw%0d_wrap_up", n), idx, n - 1, 4'b0110);
            rel(idx);
            press(idx, 1'b0);
            f = {1'b0, 1'b1, 1'b0, (n == 2)};
            chk_state($sformatf("sw%0d_up", n), idx, n - 2, f);
            rel(idx);
            press(idx, 1'b1);
            chk_state($sformatf("sw%0d_dn", n), idx, n - 1, 4'b0110);
            rel(idx);
        end

        // Auto-repeat: steps expected at edges 0, 10, 14, 18, 22, 26.
        exp_sel = 0;
        dn_v[2] = 1'b1;
        for (int e = 0; e < 30; e++) begin
            bit stepped;
            tick();
            stepped = (e == 0 || e == 10 || e == 14 || e == 18 || e == 22 || e == 26);
            if (stepped) exp_sel++;
            check($sformatf("rep_e%0d_sel", e), sel_of(2), 32'(exp_sel));
            check($sformatf("rep_e%0d_chg", e), 32'(rep_chg), 32'(stepped));
        end
        dn_v[2] = 1'b0;
        repeat (8) tick();
        chk_state("rep_after_rel", 2, 6, 4'b0000);

        // Simultaneous rise on both buttons.
        up_v[0] = 1'b1;
        dn_v[0] = 1'b1;
        tick();
        chk_state("simul_e0", 0, 1, 4'b0000);
        tick();
        chk_state("simul_e1", 0, 1, 4'b0000);
        rel(0);

        // Opposite button during HOLD aborts with no step either way.
        press(2, 1'b1);
        chk_state("abort_press", 2, 7, 4'b0110);
        repeat (3) tick();
        up_v[2] = 1'b1;
        tick();
        chk_state("abort_edge", 2, 7, 4'b0010);
        repeat (15) tick();
        chk_state("abort_hold", 2, 7, 4'b0010);
        rel(2);
        chk_state("abort_rel", 2, 7, 4'b0010);

        // Reset while REPEAT is active, then a button held through reset.
        press(2, 1'b1);
        chk_state("mid_wrap", 2, 0, 4'b0101);
        repeat (12) tick();
        chk_state("mid_rep", 2, 1, 4'b0000);
        nrst = 1'b0;
        #1;
        chk_state("mid_rst_rep", 2, 0, 4'b0001);
        check("mid_rst_def", sel_of(0), 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (20) tick();
        chk_state("held_thru_rst", 2, 0, 4'b0001);
        rel(2);
        chk_state("held_rel", 2, 0, 4'b0001);
        press(2, 1'b1);
        chk_state("fresh_press", 2, 1, 4'b0100);
        rel(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/octave_sel.md
# octave_sel

Parametrised octave selector for the synth front panel. It turns the `oct_up` and `oct_down` button levels into a saturating or wrapping octave index, with optional hold-to-auto-repeat. The index drives the octave-shift stage of the note datapath, and the block also raises change and limit pulses for the display logic. `oct_sel` counts octaves *below* the base pitch: `oct_down` increments it and `oct_up` decrements it.

## Interface
Parameters:
- `NUM_OCT`, default 4: number of selectable octaves, 2..16. The index width is W = $clog2(NUM_OCT).
- `RESET_OCT`, default 0: index loaded on reset. Must be less than NUM_OCT.
- `WRAP`, default 1: 1 means wrap around at both ends; 0 means saturate at 0 and NUM_OCT-1.
- `REPEAT_DLY`, default 0: hold cycles before auto-repeat starts. 0 disables auto-repeat. Maximum 65535.
- `REPEAT_PER`, default 1: cycles between auto-repeat steps. Range 1..65535.

Ports:
- `clk`, input, 1 bit: system clock. One clock domain only.
- `nrst`, input, 1 bit: reset, asynchronous and active-low.
- `oct_up`, input, 1 bit: up-button level, already synchronised and debounced.
- `oct_down`, input, 1 bit: down-button level, already synchronised and debounced.
- `oct_sel`, output, W bits: current octave index, registered.
- `oct_changed`, output, 1 bit: one-cycle pulse in the first cycle a new `oct_sel` value is visible.
- `limit_hit`, output, 1 bit: one-cycle pulse when a step is refused at an end. Only occurs when WRAP=0.
- `at_min`, output, 1 bit: high when `oct_sel` == 0.
- `at_max`, output, 1 bit: high when `oct_sel` == NUM_OCT-1.

## Operation
Reset values:
- `oct_sel` = RESET_OCT.
- `oct_changed` = 0 and `limit_hit` = 0.
- `at_min` and `at_max` take the values implied by RESET_OCT.
- FSM is in IDLE; hold counter = 0.
- Previous-input registers reset to 1, so a button held through reset does not produce a step.

Edge detection:
- A press is the input at 1 in the current sample with the previous sample at 0.
- If both inputs are high in the same cycle, or both show a press in the same cycle, the cycle counts as no press.

Step rules:
- Down step: if `oct_sel` < NUM_OCT-1, add 1.
  - At NUM_OCT-1 with WRAP=1: go to 0.
  - At NUM_OCT-1 with WRAP=0: `oct_sel` holds and `limit_hit` pulses.
- Up step: symmetric at 0. With WRAP=1 it wraps to NUM_OCT-1.
- `oct_changed` pulses only when the value actually changes.

FSM states: IDLE, HOLD, REPEAT. A direction register `dir` records which button is being held.
- IDLE:
  - A press on exactly one input performs a step, loads `dir`, clears the counter and moves to HOLD.
- HOLD:
  - If the held input drops, or the opposite input rises, go to IDLE with no step.
  - With REPEAT_DLY=0, stay in HOLD until release.
  - Otherwise increment the counter. When the counter equals REPEAT_DLY-1, perform a step, clear the counter and go to REPEAT.
- REPEAT:
  - The same release and opposite-input abort rules as HOLD apply.
  - Increment the counter. When the counter equals REPEAT_PER-1, perform a step and clear the counter.
- An opposite-button press while leaving HOLD or REPEAT is ignored. The next press must come from IDLE.
- The counter is 16 bits wide and is cleared on every state change.

## Timing
- A press sampled at edge k updates `oct_sel` at edge k, so the new value is visible in cycle k+1. That is one cycle of latency from the first high sample.
- `oct_changed` and `limit_hit` are registered and coincide with the cycle in which the new value, or the refused value, is first visible.
- With the button held continuously from edge k:
  - The first auto step lands at edge k+REPEAT_DLY.
  - Later auto steps land every REPEAT_PER edges.
- `at_min` and `at_max` are decoded from the `oct_sel` register and carry no added latency.
- Asserting `nrst` mid-hold or mid-repeat immediately forces all reset values.
  - After release, a still-held button does nothing until it is released and pressed again.
- Maximum step rate is one step per cycle, reached when REPEAT_PER=1.

## Test plan
- Reset and wrap, defaults (NUM_OCT=4, WRAP=1): pulse `oct_down` high for 1 cycle, 5 times, with low cycles between. Expected `oct_sel`: 1, 2, 3, 0, 1, with an `oct_changed` pulse on each step.
- Saturation (WRAP=0, NUM_OCT=3): from 0, 3 down presses give `oct_sel` 1, 2, 2. The third press pulses `limit_hit` and does not pulse `oct_changed`. One up press then gives 1. `at_max` is high only while `oct_sel` = 2.
- Auto-repeat (REPEAT_DLY=10, REPEAT_PER=4, NUM_OCT=8): hold `oct_down` for 30 cycles starting at edge 0. Expected steps at edges 0, 10, 14, 18, 22, 26, giving final `oct_sel` = 6. No further steps after release.
- Simultaneous inputs: `oct_up` and `oct_down` rise on the same edge, leaving `oct_sel` unchanged. Separately, during HOLD on down, raise `oct_up`: expect an abort to IDLE with no step in either direction.
- Reset mid-repeat and reset with a held button: assert `nrst` while REPEAT is active. Expect `oct_sel` = RESET_OCT at once, and still no step while `oct_down` stays high after reset. The next fresh press must step normally.
- Parameter sweep: NUM_OCT ∈ {2, 5, 16} and RESET_OCT = NUM_OCT-1. Check W, the reset value, and wrap at both ends in both directions.
